// File: rtl/rf_dump_reader.sv
// Streams a range of integer register file entries out over valid/ready.
// Reads through the asynchronous rs port; rd_addr is always the registered walk pointer.
module rf_dump_reader #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned DW    = 32,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] first_idx,
  input  logic [AW-1:0] last_idx,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          out_last
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        r_state, w_next;
  logic [AW-1:0] r_ptr, r_last;
  logic          r_issued_last;
  logic          r_out_valid, r_out_last, r_done, r_err;
  logic [DW-1:0] r_out_data;
  logic [AW-1:0] r_out_idx;

  logic w_accept, w_range_ok, w_slot_free, w_handshake, w_capture, w_final_hs;

  assign w_accept    = (r_state == IDLE) && start && !abort;
  assign w_range_ok  = (first_idx <= last_idx);
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_handshake = r_out_valid && out_ready;
  assign w_capture   = (r_state == ACTIVE) && !abort && w_slot_free && !r_issued_last;
  assign w_final_hs  = w_handshake && r_out_last;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept && w_range_ok) w_next = ACTIVE;
      ACTIVE:  if (abort || w_final_hs)    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr         <= '0;
      r_last        <= '0;
      r_issued_last <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_out_data    <= '0;
      r_out_idx     <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_accept) begin
        if (w_range_ok) begin
          r_ptr         <= first_idx;
          r_last        <= last_idx;
          r_issued_last <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
      end
      if (r_state == ACTIVE) begin
        if (abort) begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end else if (w_final_hs) begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_done      <= 1'b1;
        end else if (w_capture) begin
          // Capture replaces a beat handshaking this cycle, giving one beat per cycle.
          r_out_data  <= rd_data;
          r_out_idx   <= r_ptr;
          r_out_last  <= (r_ptr == r_last);
          r_out_valid <= 1'b1;
          if (r_ptr == r_last) r_issued_last <= 1'b1;
          else                 r_ptr         <= r_ptr + AW'(1);
        end else if (w_handshake) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign rd_addr   = r_ptr;
  assign done      = r_done;
  assign err       = r_err;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader with a behavioural register file on the read port.
module tb_rf_dump_reader;

  logic        clk = 1'b0;
  logic        rst, start, abort, out_ready;
  logic [4:0]  first_idx, last_idx;
  logic        busy, done, err, out_valid, out_last;
  logic [4:0]  rd_addr, out_idx;
  logic [31:0] rd_data, out_data;
  logic [31:0] regs [32];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;
  assign rd_data = regs[rd_addr];

  rf_dump_reader #(.NREGS(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .start(start), .first_idx(first_idx), .last_idx(last_idx),
    .abort(abort), .busy(busy), .done(done), .err(err), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic launch(input logic [4:0] f, input logic [4:0] l);
    first_idx = f;
    last_idx  = l;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Drives out_ready from a repeating 7-cycle pattern and checks every accepted beat
  // and every stalled cycle until done appears or the budget runs out.
  task automatic collect(input logic [4:0] exp_first, input logic [4:0] exp_last,
                         input logic [6:0] pat, input int budget, output int beats);
    logic        h_v;
    logic [31:0] h_d;
    logic [4:0]  h_i;
    logic        h_l;
    logic        seen;
    logic [4:0]  nxt;
    h_v = 1'b0; h_d = '0; h_i = '0; h_l = 1'b0;
    seen = 1'b0;
    nxt = exp_first;
    beats = 0;
    for (int c = 0; c < budget; c++) begin
      if (done) begin
        seen = 1'b1;
        chk_eq("done_busy", {31'd0, busy}, 32'd0);
        chk_eq("done_valid", {31'd0, out_valid}, 32'd0);
        break;
      end
      if (h_v) begin
        chk_eq("hold_valid", {31'd0, out_valid}, 32'd1);
        chk_eq("hold_data", out_data, h_d);
        chk_eq("hold_idx", {27'd0, out_idx}, {27'd0, h_i});
        chk_eq("hold_last", {31'd0, out_last}, {31'd0, h_l});
      end
      out_ready = pat[c % 7];
      h_v = out_valid && !out_ready;
      h_d = out_data; h_i = out_idx; h_l = out_last;
      if (out_valid && out_ready) begin
        chk_eq("beat_idx", {27'd0, out_idx}, {27'd0, nxt});
        chk_eq("beat_data", out_data, regs[nxt]);
        chk_eq("beat_last", {31'd0, out_last}, {31'd0, (nxt == exp_last)});
        nxt = nxt + 5'd1;
        beats++;
      end
      tick();
    end
    chk_eq("done_seen", {31'd0, seen}, 32'd1);
  endtask

  int nb;

  initial begin
    for (int k = 0; k < 32; k++) regs[k] = 32'h1000_0000 + k;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    first_idx = '0; last_idx = '0;
    tick(); tick();
    rst = 1'b0;
    chk_eq("rst_busy", {31'd0, busy}, 32'd0);
    chk_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    chk_eq("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
    chk_eq("rst_done_err", {30'd0, done, err}, 32'd0);

    // Full dump 0..31, ready held high.
    out_ready = 1'b1;
    launch(5'd0, 5'd31);
    chk_eq("lat_busy", {31'd0, busy}, 32'd1);
    chk_eq("lat_valid_c1", {31'd0, out_valid}, 32'd0);
    tick();
    chk_eq("lat_valid_c2", {31'd0, out_valid}, 32'd1);
    collect(5'd0, 5'd31, 7'b1111111, 60, nb);
    chk_eq("full_beats", nb, 32);
    tick();
    chk_eq("full_done_once", {31'd0, done}, 32'd0);

    // Stuttering ready 1,0,0,1,1,0,1 over 5..8.
    launch(5'd5, 5'd8);
    collect(5'd5, 5'd8, 7'b1011001, 60, nb);
    chk_eq("bp_beats", nb, 4);

    // Single-register dump.
    out_ready = 1'b1;
    launch(5'd3, 5'd3);
    collect(5'd3, 5'd3, 7'b1111111, 20, nb);
    chk_eq("single_beats", nb, 1);

    // Inverted range.
    launch(5'd9, 5'd4);
    chk_eq("err_pulse", {31'd0, err}, 32'd1);
    chk_eq("err_busy", {31'd0, busy}, 32'd0);
    chk_eq("err_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk_eq("err_clear", {31'd0, err}, 32'd0);
    chk_eq("err_busy2", {31'd0, busy}, 32'd0);

    // Coherency: write reg 15 while beat 12 stalls; a second start is ignored.
    out_ready = 1'b0;
    launch(5'd10, 5'd20);
    tick();
    chk_eq("coh_b10", {27'd0, out_idx}, 32'd10);
    out_ready = 1'b1;
    tick();
    chk_eq("coh_b11", {27'd0, out_idx}, 32'd11);
    tick();
    chk_eq("coh_b12", {27'd0, out_idx}, 32'd12);
    out_ready = 1'b0;
    regs[15] = 32'hDEAD_BEEF;
    launch(5'd0, 5'd31);
    chk_eq("coh_hold12", {27'd0, out_idx}, 32'd12);
    collect(5'd12, 5'd20, 7'b1111111, 40, nb);
    chk_eq("coh_beats", nb + 2, 11);
    regs[15] = 32'h1000_000F;

    // Abort while beat 6 is valid and being accepted.
    out_ready = 1'b1;
    launch(5'd4, 5'd10);
    tick(); tick(); tick();
    chk_eq("ab_idx6", {27'd0, out_idx}, 32'd6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_eq("ab_valid", {31'd0, out_valid}, 32'd0);
    chk_eq("ab_busy", {31'd0, busy}, 32'd0);
    chk_eq("ab_last", {31'd0, out_last}, 32'd0);
    chk_eq("ab_done", {31'd0, done}, 32'd0);
    tick();
    chk_eq("ab_done2", {31'd0, done}, 32'd0);
    launch(5'd0, 5'd2);
    collect(5'd0, 5'd2, 7'b1111111, 20, nb);
    chk_eq("ab_restart_beats", nb, 3);

    // Same scenario with rst.
    launch(5'd4, 5'd10);
    tick(); tick(); tick();
    chk_eq("rs_idx6", {27'd0, out_idx}, 32'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_eq("rs_valid", {31'd0, out_valid}, 32'd0);
    chk_eq("rs_busy", {31'd0, busy}, 32'd0);
    chk_eq("rs_flags", {29'd0, done, err, out_last}, 32'd0);
    chk_eq("rs_data", out_data, 32'd0);
    chk_eq("rs_idx", {27'd0, out_idx}, 32'd0);
    chk_eq("rs_rd_addr", {27'd0, rd_addr}, 32'd0);
    tick();
    chk_eq("rs_done2", {30'd0, done, err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
